// File: rtl/Thor2024_cache_pkg.sv
// Shared cache types: the line width that the SRAM defaults to, and the encoding of its clear FSM.
package Thor2024_cache_pkg;

    typedef logic [511:0] ICacheLine;

    localparam int ICACHE_LINES = 512;

    typedef enum logic {
        SRAM_IDLE,
        SRAM_CLEAR
    } sram_state_t;

endpackage

// File: rtl/sram_1r1w_core.sv
// Plain simple-dual-port array: byte-lane write, registered read-first read.
// The array has no reset.
module sram_1r1w_core #(
    parameter  int WIDTH = 512,
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [NB-1:0]    wsel,
    input  logic [AW-1:0]    wadr,
    input  logic [WIDTH-1:0] i,
    input  logic             re,
    input  logic [AW-1:0]    radr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // A same-address read sees the old entry because both updates are non-blocking.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < NB; k++) begin
                if (wsel[k]) begin
                    mem[wadr][8*k +: 8] <= i[8*k +: 8];
                end
            end
        end
        if (re) begin
            q <= mem[radr];
        end
    end

endmodule

// File: rtl/sram_1r1w_clr.sv
// Cache line/tag SRAM with a hardware clear sweep, same-cycle write forwarding
// and a selectable 1- or 2-cycle read latency.
module sram_1r1w_clr
    import Thor2024_cache_pkg::*;
#(
    parameter  int WIDTH  = $bits(ICacheLine),
    parameter  int DEPTH  = ICACHE_LINES,
    parameter  int RD_LAT = 1,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int NB     = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req,
    output logic             busy,
    input  logic             wr,
    input  logic [NB-1:0]    wsel,
    input  logic [AW-1:0]    wadr,
    input  logic [WIDTH-1:0] i,
    input  logic             rd,
    input  logic [AW-1:0]    radr,
    output logic [WIDTH-1:0] o,
    output logic             ov
);

    sram_state_t      state;
    logic [AW-1:0]    cnt;
    logic             idle;
    logic             wr_ok;
    logic             rd_ok;

    logic             mem_we;
    logic [NB-1:0]    mem_wsel;
    logic [AW-1:0]    mem_wadr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] q;

    logic             v1;
    logic             hit1;
    logic [NB-1:0]    wsel1;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] ohold;

    assign idle  = (state == SRAM_IDLE);
    assign busy  = (state == SRAM_CLEAR);
    // A clear request in the same cycle drops both ports, so the sweep always wins.
    assign wr_ok = rst && idle && !clr_req && wr;
    assign rd_ok = rst && idle && !clr_req && rd;

    always_ff @(posedge clk) begin
        if (!rst || clr_req) begin
            state <= SRAM_CLEAR;
            cnt   <= '0;
        end else if (state == SRAM_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1)) begin
                state <= SRAM_IDLE;
            end
        end
    end

    assign mem_we    = busy ? 1'b1 : wr_ok;
    assign mem_wsel  = busy ? '1   : wsel;
    assign mem_wadr  = busy ? cnt  : wadr;
    assign mem_wdata = busy ? '0   : i;

    sram_1r1w_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk  (clk),
        .we   (mem_we),
        .wsel (mem_wsel),
        .wadr (mem_wadr),
        .i    (mem_wdata),
        .re   (rd_ok),
        .radr (radr),
        .q    (q)
    );

    // The write lanes are registered alongside the read so the merge never sees i directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1   <= 1'b0;
            hit1 <= 1'b0;
        end else begin
            v1   <= rd_ok;
            hit1 <= (BYPASS != 0) && rd_ok && wr_ok && (radr == wadr);
        end
        if (wr_ok) begin
            wsel1 <= wsel;
            i1    <= i;
        end
    end

    always_comb begin
        merged = q;
        for (int k = 0; k < NB; k++) begin
            if (hit1 && wsel1[k]) begin
                merged[8*k +: 8] = i1[8*k +: 8];
            end
        end
    end

    // Holds the last returned line between reads; forced to zero by reset and clear.
    always_ff @(posedge clk) begin
        if (!rst || clr_req || busy) begin
            ohold <= '0;
        end else if (v1) begin
            ohold <= merged;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic v2;

            always_ff @(posedge clk) begin
                if (!rst || clr_req) begin
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                end
            end

            assign o  = ohold;
            assign ov = v2;
        end else begin : g_lat1
            assign o  = v1 ? merged : ohold;
            assign ov = v1;
        end
    endgenerate

endmodule

// File: tb/tb_sram_1r1w_clr.sv
// Scoreboard bench: one RD_LAT=1/BYPASS=1 instance and one RD_LAT=2/BYPASS=0 instance
// share all inputs; each has its own expected-read queue.
module tb_sram_1r1w_clr;
    import Thor2024_cache_pkg::*;

    localparam int W     = $bits(ICacheLine);
    localparam int NB    = W / 8;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    localparam ICacheLine P5A  = {64{8'h5A}};
    localparam ICacheLine P55  = {64{8'h55}};
    localparam ICacheLine P11  = {64{8'h11}};
    localparam ICacheLine ZERO = '0;
    localparam ICacheLine ONES = '1;

    typedef struct {
        ICacheLine data;
        int        due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_req;
    logic          wr;
    logic          rd;
    logic [NB-1:0] wsel;
    logic [AW-1:0] wadr;
    logic [AW-1:0] radr;
    ICacheLine     i;
    ICacheLine     o1;
    ICacheLine     o2;
    logic          ov1;
    logic          ov2;
    logic          busy1;
    logic          busy2;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_1r1w_clr #(.RD_LAT(1), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
        .wr(wr), .wsel(wsel), .wadr(wadr), .i(i),
        .rd(rd), .radr(radr), .o(o1), .ov(ov1)
    );

    sram_1r1w_clr #(.RD_LAT(2), .BYPASS(0)) dut2 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy2),
        .wr(wr), .wsel(wsel), .wadr(wadr), .i(i),
        .rd(rd), .radr(radr), .o(o2), .ov(ov2)
    );

    task automatic checkOutput(input string name, input ICacheLine act, input ICacheLine exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkScalar(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        clr_req = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        wsel    = '0;
        wadr    = '0;
        radr    = '0;
        i       = '0;
    endtask

    task automatic applyStimulus(input bit w, input logic [NB-1:0] ws, input int wa, input ICacheLine d,
                                 input bit r, input int ra, input ICacheLine ea, input ICacheLine eb);
        clr_req = 1'b0;
        wr      = w;
        wsel    = ws;
        wadr    = AW'(wa);
        i       = d;
        rd      = r;
        radr    = AW'(ra);
        if (r) begin
            q1.push_back('{data: ea, due: cyc + 1});
            q2.push_back('{data: eb, due: cyc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic startClear(input bit w, input int wa);
        idleInputs();
        clr_req = 1'b1;
        wr      = w;
        wsel    = '1;
        wadr    = AW'(wa);
        i       = ONES;
        @(posedge clk);
        #1;
        idleInputs();
    endtask

    task automatic countBusy(output int n);
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!busy1) break;
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        idleInputs();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Any ov with nothing queued is an unexpected response.
    always @(negedge clk) begin
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL rdA_unexpected: got ov=1 want ov=0 at cycle %0d", cyc);
            end else begin
                e1 = q1.pop_front();
                checkOutput("rdA_data", o1, e1.data);
                checkScalar("rdA_cycle", cyc, e1.due);
            end
        end
        if (ov2 === 1'b1) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL rdB_unexpected: got ov=1 want ov=0 at cycle %0d", cyc);
            end else begin
                e2 = q2.pop_front();
                checkOutput("rdB_data", o2, e2.data);
                checkScalar("rdB_cycle", cyc, e2.due);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int        n;
        logic [7:0] b;
        ICacheLine fill [4];
        ICacheLine mixed;
        ICacheLine expA;

        idleInputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkScalar("reset_ovA", int'(ov1), 0);
        checkScalar("reset_ovB", int'(ov2), 0);
        checkScalar("reset_busy", int'(busy1), 1);
        checkOutput("reset_oA", o1, ZERO);
        checkOutput("reset_oB", o2, ZERO);

        rst = 1'b1;
        countBusy(n);
        checkScalar("sweep_len_reset", n, DEPTH);
        checkScalar("busyB_after_reset", int'(busy2), 0);
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b0, '0, 0, ZERO, 1'b1, a, ZERO, ZERO);
        end
        settle();

        applyStimulus(1'b1, '1, 5, P5A, 1'b0, 0, ZERO, ZERO);
        applyStimulus(1'b0, '0, 0, ZERO, 1'b1, 5, P5A, P5A);
        applyStimulus(1'b1, '0, 5, ONES, 1'b0, 0, ZERO, ZERO);
        applyStimulus(1'b0, '0, 0, ZERO, 1'b1, 5, P5A, P5A);
        settle();

        mixed      = P11;
        mixed[7:0] = 8'hAA;
        expA       = P55;
        expA[7:0]  = 8'hAA;
        applyStimulus(1'b1, '1, 7, P55, 1'b0, 0, ZERO, ZERO);
        applyStimulus(1'b1, NB'(1), 7, mixed, 1'b1, 7, expA, P55);
        applyStimulus(1'b0, '0, 0, ZERO, 1'b1, 7, expA, expA);
        settle();

        for (int a = 0; a < 4; a++) begin
            b       = 8'h10 + 8'(a);
            fill[a] = {64{b}};
            applyStimulus(1'b1, '1, a, fill[a], 1'b0, 0, ZERO, ZERO);
        end
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b0, '0, 0, ZERO, 1'b1, a, fill[a], fill[a]);
        end
        settle();
        startClear(1'b1, 2);
        countBusy(n);
        checkScalar("sweep_len_clr", n, DEPTH);
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b0, '0, 0, ZERO, 1'b1, a, ZERO, ZERO);
        end
        settle();

        // Reads held high during the sweep must be dropped; reset lands at count 100.
        applyStimulus(1'b1, '1, 9, P5A, 1'b0, 0, ZERO, ZERO);
        startClear(1'b0, 0);
        rd   = 1'b1;
        radr = AW'(9);
        repeat (100) @(posedge clk);
        #1;
        rd  = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkScalar("midreset_busy", int'(busy1), 1);
        checkOutput("midreset_oA", o1, ZERO);
        rst = 1'b1;
        countBusy(n);
        checkScalar("sweep_len_midreset", n, DEPTH);
        applyStimulus(1'b0, '0, 0, ZERO, 1'b1, 9, ZERO, ZERO);
        settle();

        for (int a = 1; a < 4; a++) begin
            applyStimulus(1'b1, '1, a, fill[a], 1'b0, 0, ZERO, ZERO);
        end
        for (int a = 1; a < 4; a++) begin
            applyStimulus(1'b0, '0, 0, ZERO, 1'b1, a, fill[a], fill[a]);
        end
        idleInputs();
        repeat (5) @(posedge clk);
        #1;
        checkOutput("holdA", o1, fill[3]);
        checkOutput("holdB", o2, fill[3]);
        checkScalar("ovA_idle", int'(ov1), 0);
        checkScalar("ovB_idle", int'(ov2), 0);

        checkScalar("drainA", q1.size(), 0);
        checkScalar("drainB", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
